// File: rtl/rcg_ctrl_mod_rsp.sv
// rcg_ctrl_mod_rsp: module-side responder for the RCC clock-disable handshake.
// On a synchronised mod_disable_req it closes the transaction admission gate.
// It then drains the outstanding transactions, waits QUIET_CYC idle cycles and
// raises mod_disable_ack. Ports:
//   clk_in, hgrst_n (async, active-low), mod_rst_n (sync clear)
//   mod_disable_req -> mod_disable_ack  : RCC handshake
//   txn_req/txn_gnt/txn_done            : admission gate and completions
//   outstanding, drain_busy, cnt_err    : status
//   tmo_cfg, drain_tmo, mod_hw_rst_req  : drain watchdog
// The watchdog exists only when RCG_CTRL_MOD_RSP_TMO_EN is defined.
// Otherwise tmo_cfg is ignored and both watchdog outputs are tied low.
module rcg_ctrl_mod_rsp #(
  parameter int CNT_W     = 4,
  parameter int QUIET_CYC = 4
) (
  input  logic             clk_in,
  input  logic             hgrst_n,
  input  logic             mod_rst_n,
  input  logic             mod_disable_req,
  output logic             mod_disable_ack,
  input  logic             txn_req,
  output logic             txn_gnt,
  input  logic             txn_done,
  input  logic [7:0]       tmo_cfg,
  output logic [CNT_W-1:0] outstanding,
  output logic             drain_busy,
  output logic             cnt_err,
  output logic             drain_tmo,
  output logic             mod_hw_rst_req
);

  localparam int QW =
    (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [QW-1:0] QLOAD = QW'(QUIET_CYC - 1);

  typedef enum logic [1:0] {
    RUN, BLOCK, QUIET, ACK
  } state_t;

  state_t           state_q, state_d;
  logic             req_s1_q, req_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             expire;

  always_ff @(posedge clk_in or negedge hgrst_n) begin
    if (!hgrst_n) begin
      req_s1_q <= 1'b0;
      req_s_q  <= 1'b0;
    end else begin
      req_s1_q <= mod_disable_req;
      req_s_q  <= req_s1_q;
    end
  end

  assign txn_gnt = txn_req
                 & (state_q == RUN)
                 & (cnt_q != CNT_MAX);

  // A grant and a completion in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({txn_gnt, txn_done})
      2'b10: cnt_d = cnt_q + CNT_W'(1);
      2'b01: begin
        if (cnt_q == '0) err_d = 1'b1;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
    if (!mod_rst_n) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    unique case (state_q)
      RUN: begin
        if (req_s_q) state_d = BLOCK;
      end
      BLOCK: begin
        if (!req_s_q) begin
          state_d = RUN;
        end else if (cnt_q == '0 || expire) begin
          state_d = QUIET;
          qcnt_d  = QLOAD;
        end
      end
      QUIET: begin
        if (!req_s_q) state_d = RUN;
        else if (qcnt_q == '0) state_d = ACK;
        else qcnt_d = qcnt_q - QW'(1);
      end
      ACK: begin
        if (!req_s_q) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!mod_rst_n) begin
      state_d = RUN;
      qcnt_d  = '0;
    end
  end

  assign ack_d = (state_d == ACK);

  always_ff @(posedge clk_in or negedge hgrst_n) begin
    if (!hgrst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      qcnt_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qcnt_q  <= qcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign mod_disable_ack = ack_q;
  assign outstanding     = cnt_q;
  assign cnt_err         = err_q;
  assign drain_busy      = (state_q == BLOCK)
                         | (state_q == QUIET);

`ifdef RCG_CTRL_MOD_RSP_TMO_EN
  logic [7:0] tcnt_q, tcnt_d;
  logic       tmo_q, tmo_d;
  logic       hw_q, hw_d;

  // Fires on the tmo_cfg-th BLOCK cycle, and only if it is what moves the
  // FSM on: an abort or a natural drain takes precedence.
  assign expire = (state_q == BLOCK)
                & req_s_q
                & (cnt_q != '0)
                & (tmo_cfg != 8'd0)
                & ((tcnt_q + 8'd1) == tmo_cfg);

  always_comb begin
    tcnt_d = 8'd0;
    if (state_q == BLOCK && state_d == BLOCK)
      tcnt_d = tcnt_q + 8'd1;
    tmo_d = tmo_q | expire;
    hw_d  = expire;
    if (!mod_rst_n) begin
      tmo_d = 1'b0;
      hw_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge hgrst_n) begin
    if (!hgrst_n) begin
      tcnt_q <= 8'd0;
      tmo_q  <= 1'b0;
      hw_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
      hw_q   <= hw_d;
    end
  end

  assign drain_tmo      = tmo_q;
  assign mod_hw_rst_req = hw_q;
`else
  logic unused_tmo;
  assign unused_tmo     = ^tmo_cfg;
  assign expire         = 1'b0;
  assign drain_tmo      = 1'b0;
  assign mod_hw_rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_rcg_ctrl_mod_rsp.sv
// tb_rcg_ctrl_mod_rsp: directed and randomised checks of rcg_ctrl_mod_rsp.
// Expected latencies come from the handshake timing rules, counts from a model.
module tb_rcg_ctrl_mod_rsp;
  localparam int CNT_W = 4;
  localparam int QC    = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int IDLE_LAT = 4 + QC;

  logic             clk_in = 1'b0;
  logic             hgrst_n;
  logic             mod_rst_n;
  logic             mod_disable_req;
  logic             mod_disable_ack;
  logic             txn_req;
  logic             txn_gnt;
  logic             txn_done;
  logic [7:0]       tmo_cfg;
  logic [CNT_W-1:0] outstanding;
  logic             drain_busy;
  logic             cnt_err;
  logic             drain_tmo;
  logic             mod_hw_rst_req;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  rcg_ctrl_mod_rsp #(
    .CNT_W(CNT_W),
    .QUIET_CYC(QC)
  ) dut (
    .clk_in(clk_in),
    .hgrst_n(hgrst_n),
    .mod_rst_n(mod_rst_n),
    .mod_disable_req(mod_disable_req),
    .mod_disable_ack(mod_disable_ack),
    .txn_req(txn_req),
    .txn_gnt(txn_gnt),
    .txn_done(txn_done),
    .tmo_cfg(tmo_cfg),
    .outstanding(outstanding),
    .drain_busy(drain_busy),
    .cnt_err(cnt_err),
    .drain_tmo(drain_tmo),
    .mod_hw_rst_req(mod_hw_rst_req)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ack(input logic lvl,
                          input int bound,
                          output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (mod_disable_ack === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_grants(input int n);
    txn_req = 1'b1;
    repeat (n) step();
    txn_req = 1'b0;
    exp_cnt += n;
  endtask

  task automatic test_reset();
    hgrst_n = 1'b0;
    #12;
    checks++;
    if ({mod_disable_ack, drain_busy, cnt_err,
         drain_tmo, mod_hw_rst_req} !== 5'b0) begin
      failures++;
      $display("FAIL rst_flags: got %b exp 00000",
        {mod_disable_ack, drain_busy, cnt_err,
         drain_tmo, mod_hw_rst_req});
    end
    checks++;
    if (outstanding !== '0) begin
      failures++;
      $display("FAIL rst_cnt: got %0d exp 0", outstanding);
    end
    txn_req = 1'b1;
    #1;
    checks++;
    if (txn_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rst_gnt1: got %b exp 1", txn_gnt);
    end
    txn_req = 1'b0;
    #1;
    checks++;
    if (txn_gnt !== 1'b0) begin
      failures++;
      $display("FAIL rst_gnt0: got %b exp 0", txn_gnt);
    end
    hgrst_n = 1'b1;
    step();
    step();
    checks++;
    if (mod_disable_ack !== 1'b0 || outstanding !== '0) begin
      failures++;
      $display("FAIL post_rst: ack %b cnt %0d exp 0 0",
        mod_disable_ack, outstanding);
    end
  endtask

  task automatic test_idle_drain();
    int n;
    mod_disable_req = 1'b1;
    wait_ack(1'b1, 40, n);
    checks++;
    if (n !== IDLE_LAT) begin
      failures++;
      $display("FAIL idle_ack_lat: got %0d exp %0d", n, IDLE_LAT);
    end
    txn_req = 1'b1;
    #1;
    checks++;
    if (txn_gnt !== 1'b0) begin
      failures++;
      $display("FAIL idle_gate_closed: got %b exp 0", txn_gnt);
    end
    txn_req = 1'b0;
    mod_disable_req = 1'b0;
    wait_ack(1'b0, 20, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL idle_release_lat: got %0d exp 3", n);
    end
    txn_req = 1'b1;
    #1;
    checks++;
    if (txn_gnt !== 1'b1) begin
      failures++;
      $display("FAIL idle_gate_open: got %b exp 1", txn_gnt);
    end
    txn_req = 1'b0;
  endtask

  task automatic test_busy_drain();
    int n;
    do_grants(3);
    checks++;
    if (outstanding !== CNT_W'(exp_cnt)) begin
      failures++;
      $display("FAIL busy_cnt3: got %0d exp %0d", outstanding, exp_cnt);
    end
    // Keep requesting: grants up to the last RUN cycle are admitted.
    txn_req = 1'b1;
    mod_disable_req = 1'b1;
    step();
    step();
    exp_cnt += 2;
    checks++;
    if (txn_gnt !== 1'b1) begin
      failures++;
      $display("FAIL busy_last_run_gnt: got %b exp 1", txn_gnt);
    end
    step();
    exp_cnt += 1;
    checks++;
    if (txn_gnt !== 1'b0 || outstanding !== CNT_W'(exp_cnt)) begin
      failures++;
      $display("FAIL busy_block: gnt %b cnt %0d exp 0 %0d",
        txn_gnt, outstanding, exp_cnt);
    end
    repeat (10) step();
    txn_req = 1'b0;
    checks++;
    if (mod_disable_ack !== 1'b0) begin
      failures++;
      $display("FAIL busy_ack_held: got %b exp 0", mod_disable_ack);
    end
    txn_done = 1'b1;
    repeat (exp_cnt) step();
    txn_done = 1'b0;
    exp_cnt = 0;
    wait_ack(1'b1, 40, n);
    checks++;
    if (n !== 1 + QC) begin
      failures++;
      $display("FAIL busy_ack_lat: got %0d exp %0d", n, 1 + QC);
    end
    mod_disable_req = 1'b0;
    wait_ack(1'b0, 20, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL busy_release_lat: got %0d exp 3", n);
    end
  endtask

  task automatic test_counter();
    do_grants(2);
    txn_req  = 1'b1;
    txn_done = 1'b1;
    #1;
    checks++;
    if (txn_gnt !== 1'b1) begin
      failures++;
      $display("FAIL cnt_both_gnt: got %b exp 1", txn_gnt);
    end
    step();
    checks++;
    if (outstanding !== CNT_W'(2)) begin
      failures++;
      $display("FAIL cnt_both: got %0d exp 2", outstanding);
    end
    txn_done = 1'b0;
    repeat (MAXC - 2) step();
    exp_cnt = MAXC;
    checks++;
    if (outstanding !== CNT_W'(MAXC) || txn_gnt !== 1'b0) begin
      failures++;
      $display("FAIL cnt_max: cnt %0d gnt %b exp %0d 0",
        outstanding, txn_gnt, MAXC);
    end
    step();
    txn_req = 1'b0;
    checks++;
    if (outstanding !== CNT_W'(MAXC)) begin
      failures++;
      $display("FAIL cnt_sat: got %0d exp %0d", outstanding, MAXC);
    end
    txn_done = 1'b1;
    repeat (MAXC) step();
    exp_cnt = 0;
    checks++;
    if (outstanding !== '0 || cnt_err !== 1'b0) begin
      failures++;
      $display("FAIL cnt_zero: cnt %0d err %b exp 0 0",
        outstanding, cnt_err);
    end
    step();
    txn_done = 1'b0;
    checks++;
    if (outstanding !== '0 || cnt_err !== 1'b1) begin
      failures++;
      $display("FAIL cnt_underflow: cnt %0d err %b exp 0 1",
        outstanding, cnt_err);
    end
    repeat (3) step();
    checks++;
    if (cnt_err !== 1'b1) begin
      failures++;
      $display("FAIL cnt_err_sticky: got %b exp 1", cnt_err);
    end
  endtask

  task automatic test_abort();
    int hits;
    mod_disable_req = 1'b1;
    repeat (4) step();
    checks++;
    if (drain_busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: got %b exp 1", drain_busy);
    end
    mod_disable_req = 1'b0;
    hits = 0;
    repeat (20) begin
      step();
      if (mod_disable_ack !== 1'b0) hits++;
    end
    checks++;
    if (hits !== 0) begin
      failures++;
      $display("FAIL abort_no_ack: got %0d ack cycles exp 0", hits);
    end
    txn_req = 1'b1;
    #1;
    checks++;
    if (txn_gnt !== 1'b1 || drain_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_reopen: gnt %b busy %b exp 1 0",
        txn_gnt, drain_busy);
    end
    txn_req = 1'b0;
  endtask

  task automatic test_mod_rst();
    int n;
    do_grants(5);
    mod_disable_req = 1'b1;
    repeat (6) step();
    checks++;
    if (drain_busy !== 1'b1 || outstanding !== CNT_W'(5)) begin
      failures++;
      $display("FAIL mrst_pre: busy %b cnt %0d exp 1 5",
        drain_busy, outstanding);
    end
    mod_rst_n = 1'b0;
    step();
    exp_cnt = 0;
    checks++;
    if (outstanding !== '0 || cnt_err !== 1'b0 ||
        drain_tmo !== 1'b0 || drain_busy !== 1'b0) begin
      failures++;
      $display("FAIL mrst_clear: cnt %0d err %b tmo %b busy %b exp 0",
        outstanding, cnt_err, drain_tmo, drain_busy);
    end
    mod_rst_n = 1'b1;
    // One edge back into BLOCK, then the idle path.
    wait_ack(1'b1, 40, n);
    checks++;
    if (n !== 2 + QC) begin
      failures++;
      $display("FAIL mrst_ack_lat: got %0d exp %0d", n, 2 + QC);
    end
    mod_disable_req = 1'b0;
    wait_ack(1'b0, 20, n);
  endtask

`ifdef RCG_CTRL_MOD_RSP_TMO_EN
  task automatic test_watchdog();
    int n, pulses, first_p, first_a;
    do_grants(1);
    tmo_cfg = 8'd10;
    mod_disable_req = 1'b1;
    pulses = 0;
    first_p = -1;
    first_a = -1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (mod_hw_rst_req === 1'b1) begin
        pulses++;
        if (first_p < 0) first_p = i;
      end
      if (mod_disable_ack === 1'b1 && first_a < 0) first_a = i;
    end
    // BLOCK is entered on the third edge; it lasts tmo_cfg cycles.
    checks++;
    if (pulses !== 1 || first_p !== 13) begin
      failures++;
      $display("FAIL wd_pulse: n %0d at %0d exp 1 at 13",
        pulses, first_p);
    end
    checks++;
    if (first_a !== 13 + QC) begin
      failures++;
      $display("FAIL wd_ack_lat: got %0d exp %0d", first_a, 13 + QC);
    end
    checks++;
    if (drain_tmo !== 1'b1 || outstanding !== CNT_W'(1)) begin
      failures++;
      $display("FAIL wd_flags: tmo %b cnt %0d exp 1 1",
        drain_tmo, outstanding);
    end
    mod_disable_req = 1'b0;
    wait_ack(1'b0, 20, n);
    tmo_cfg = 8'd0;
    mod_disable_req = 1'b1;
    pulses = 0;
    first_a = 0;
    repeat (300) begin
      step();
      if (mod_hw_rst_req !== 1'b0) pulses++;
      if (mod_disable_ack !== 1'b0) first_a++;
    end
    checks++;
    if (pulses !== 0 || first_a !== 0) begin
      failures++;
      $display("FAIL wd_off: pulses %0d acks %0d exp 0 0",
        pulses, first_a);
    end
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    exp_cnt = 0;
    wait_ack(1'b1, 40, n);
    checks++;
    if (n !== 1 + QC) begin
      failures++;
      $display("FAIL wd_off_drain: got %0d exp %0d", n, 1 + QC);
    end
    mod_disable_req = 1'b0;
    wait_ack(1'b0, 20, n);
    mod_rst_n = 1'b0;
    step();
    mod_rst_n = 1'b1;
    checks++;
    if (drain_tmo !== 1'b0) begin
      failures++;
      $display("FAIL wd_tmo_clear: got %b exp 0", drain_tmo);
    end
  endtask
`else
  task automatic test_watchdog();
    int n, hits;
    do_grants(1);
    tmo_cfg = 8'd10;
    mod_disable_req = 1'b1;
    hits = 0;
    repeat (40) begin
      step();
      if (mod_disable_ack !== 1'b0) hits++;
      if (mod_hw_rst_req !== 1'b0) hits++;
    end
    checks++;
    if (hits !== 0 || drain_tmo !== 1'b0) begin
      failures++;
      $display("FAIL wd_absent: hits %0d tmo %b exp 0 0",
        hits, drain_tmo);
    end
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    exp_cnt = 0;
    wait_ack(1'b1, 40, n);
    checks++;
    if (n !== 1 + QC) begin
      failures++;
      $display("FAIL wd_absent_drain: got %0d exp %0d", n, 1 + QC);
    end
    mod_disable_req = 1'b0;
    wait_ack(1'b0, 20, n);
    tmo_cfg = 8'd0;
  endtask
`endif

  task automatic test_random_count();
    logic eg;
    for (int i = 0; i < 200; i++) begin
      txn_req  = 1'($urandom_range(0, 1));
      txn_done = (exp_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      eg = txn_req && (exp_cnt < MAXC);
      #1;
      checks++;
      if (txn_gnt !== eg) begin
        failures++;
        $display("FAIL rnd_gnt[%0d]: got %b exp %b", i, txn_gnt, eg);
      end
      step();
      exp_cnt = exp_cnt + int'(eg) - int'(txn_done);
      checks++;
      if (outstanding !== CNT_W'(exp_cnt)) begin
        failures++;
        $display("FAIL rnd_cnt[%0d]: got %0d exp %0d",
          i, outstanding, exp_cnt);
      end
    end
    txn_req  = 1'b0;
    txn_done = 1'b0;
  endtask

  task automatic test_random_drain();
    int t, tz, ta, n, ex, bad;
    for (int it = 0; it < 12; it++) begin
      t = 0;
      tz = 0;
      ta = -1;
      bad = 0;
      mod_disable_req = 1'b1;
      while (ta < 0 && t < 200) begin
        txn_req = (t >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        txn_done = (t >= 3 && exp_cnt > 0)
                 ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (t >= 3 && txn_gnt !== 1'b0) bad++;
        step();
        t++;
        if (txn_done) begin
          exp_cnt--;
          if (exp_cnt == 0) tz = t;
        end
        if (mod_disable_ack === 1'b1) ta = t;
      end
      txn_req  = 1'b0;
      txn_done = 1'b0;
      ex = (tz + 1 + QC > IDLE_LAT) ? tz + 1 + QC : IDLE_LAT;
      checks++;
      if (ta !== ex || bad !== 0) begin
        failures++;
        $display("FAIL rnd_drain[%0d]: ack at %0d gnts %0d exp %0d 0",
          it, ta, bad, ex);
      end
      mod_disable_req = 1'b0;
      wait_ack(1'b0, 20, n);
      checks++;
      if (n !== 3) begin
        failures++;
        $display("FAIL rnd_release[%0d]: got %0d exp 3", it, n);
      end
      do_grants($urandom_range(0, MAXC));
    end
  endtask

  initial begin
    hgrst_n         = 1'b0;
    mod_rst_n       = 1'b1;
    mod_disable_req = 1'b0;
    txn_req         = 1'b0;
    txn_done        = 1'b0;
    tmo_cfg         = 8'd0;
    test_reset();
    test_idle_drain();
    test_busy_drain();
    test_counter();
    test_abort();
    test_mod_rst();
    test_watchdog();
    test_random_count();
    test_random_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
